// File: rtl/debug_pkg.sv
// debug_pkg: command codes, request types, latch widths, FSM states and words-per-type lookup for the debug link
package debug_pkg;
  localparam int NB_CODE   = 6;
  localparam int VALID_BIT = 25;
  localparam int NB_STATE  = 3;
  localparam logic [NB_CODE-1:0] CMD_START         = 6'b000001;
  localparam logic [NB_CODE-1:0] CMD_RESET         = 6'b000010;
  localparam logic [NB_CODE-1:0] CMD_REQ_DATA      = 6'b000011;
  localparam logic [NB_CODE-1:0] CMD_LOAD_LSB      = 6'b000100;
  localparam logic [NB_CODE-1:0] CMD_LOAD_MSB      = 6'b000101;
  localparam logic [NB_CODE-1:0] CMD_MODE_GET      = 6'b001000;
  localparam logic [NB_CODE-1:0] CMD_MODE_SET_CONT = 6'b001001;
  localparam logic [NB_CODE-1:0] CMD_MODE_SET_STEP = 6'b001010;
  localparam logic [NB_CODE-1:0] CMD_STEP          = 6'b100000;
  localparam logic [NB_CODE-1:0] CMD_GOT_DATA      = 6'b100100;
  localparam logic [NB_CODE-1:0] CMD_GIB_DATA      = 6'b100101;
  localparam logic [8:0] REQ_MEM_INSTR        = 9'd1;
  localparam logic [8:0] REQ_MEM_DATA         = 9'd2;
  localparam logic [8:0] REQ_REGISTERS        = 9'd3;
  localparam logic [8:0] REQ_PC               = 9'd4;
  localparam logic [8:0] REQ_LATCH_FETCH_DATA = 9'd8;
  localparam logic [8:0] REQ_LATCH_FETCH_CTRL = 9'd9;
  localparam logic [8:0] REQ_LATCH_DECO_DATA  = 9'd16;
  localparam logic [8:0] REQ_LATCH_DECO_CTRL  = 9'd17;
  localparam logic [8:0] REQ_LATCH_EXEC_DATA  = 9'd32;
  localparam logic [8:0] REQ_LATCH_EXEC_CTRL  = 9'd33;
  localparam logic [8:0] REQ_LATCH_MEM_DATA   = 9'd64;
  localparam logic [8:0] REQ_LATCH_MEM_CTRL   = 9'd65;
  localparam int W_WORD       = 32;
  localparam int W_FETCH_DATA = 32;
  localparam int W_FETCH_CTRL = 40;
  localparam int W_DECO_DATA  = 85;
  localparam int W_DECO_CTRL  = 48;
  localparam int W_EXEC_DATA  = 64;
  localparam int W_EXEC_CTRL  = 40;
  localparam int W_MEM_DATA   = 64;
  localparam int W_MEM_CTRL   = 40;
  localparam logic [NB_STATE-1:0] ST_IDLE     = 3'd0;
  localparam logic [NB_STATE-1:0] ST_RUN      = 3'd1;
  localparam logic [NB_STATE-1:0] ST_ARMED    = 3'd2;
  localparam logic [NB_STATE-1:0] ST_SEND     = 3'd3;
  localparam logic [NB_STATE-1:0] ST_WAIT_GIB = 3'd4;
  // Index of the final 32-bit word of the requested latch; memories, registers, PC and unknown types are one word
  function automatic logic [1:0] last_word_idx(input logic [8:0] t);
    int w;
    case (t)
      REQ_LATCH_FETCH_DATA: w = W_FETCH_DATA;
      REQ_LATCH_FETCH_CTRL: w = W_FETCH_CTRL;
      REQ_LATCH_DECO_DATA:  w = W_DECO_DATA;
      REQ_LATCH_DECO_CTRL:  w = W_DECO_CTRL;
      REQ_LATCH_EXEC_DATA:  w = W_EXEC_DATA;
      REQ_LATCH_EXEC_CTRL:  w = W_EXEC_CTRL;
      REQ_LATCH_MEM_DATA:   w = W_MEM_DATA;
      REQ_LATCH_MEM_CTRL:   w = W_MEM_CTRL;
      REQ_MEM_INSTR, REQ_MEM_DATA, REQ_REGISTERS, REQ_PC: w = W_WORD;
      default: w = W_WORD;
    endcase
    return 2'((w + W_WORD - 1) / W_WORD - 1);
  endfunction
endpackage

// File: rtl/frame_edge_detect.sv
// frame_edge_detect: remembers the previous frame's code/valid and pulses accept once per new command
module frame_edge_detect
  import debug_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NB_CODE-1:0] code,
  input  logic               valid,
  output logic               accept
);
  logic [NB_CODE-1:0] prev_code;
  logic               prev_valid;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      prev_code  <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_code  <= code;
      prev_valid <= valid;
    end
  assign accept = valid && (!prev_valid || code != prev_code);
endmodule

// File: rtl/debug_frame_controller.sv
// debug_frame_controller: decodes host debug frames, drives pipeline run/step/reset, the instruction loader and latch readback
module debug_frame_controller
  import debug_pkg::*;
#(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_ADDR_DATA     = 16,
  parameter int NB_INSTR_ADDR    = 9,
  parameter int NB_ADDR_TYPE     = 9,
  parameter int NB_WORD_IDX      = 2
)(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
  input  logic [NB_CONTROL_FRAME-1:0] i_data_word,
  input  logic                        i_halt,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  output logic                        o_pipe_enable,
  output logic                        o_pipe_reset,
  output logic [NB_ADDR_TYPE-1:0]     o_req_type,
  output logic [NB_ADDR_DATA-1:0]     o_req_addr,
  output logic [NB_WORD_IDX-1:0]      o_word_idx,
  output logic                        o_instr_we,
  output logic [NB_INSTR_ADDR-1:0]    o_instr_addr,
  output logic [NB_CONTROL_FRAME-1:0] o_instr_data
);
  logic                        accept, mode, busy, running;
  logic [NB_STATE-1:0]         state, ret_state;
  logic [NB_CODE-1:0]          code, last_code;
  logic [NB_ADDR_TYPE-1:0]     addr_type;
  logic [NB_ADDR_DATA-1:0]     address, held_lsb, status_data;
  logic [NB_INSTR_ADDR-1:0]    load_cnt;
  logic [NB_CONTROL_FRAME-1:0] status;
  assign code        = i_frame_from_blaze[NB_CONTROL_FRAME-1 -: NB_CODE];
  assign addr_type   = i_frame_from_blaze[NB_ADDR_DATA +: NB_ADDR_TYPE];
  assign address     = i_frame_from_blaze[NB_ADDR_DATA-1:0];
  assign busy        = state == ST_SEND || state == ST_WAIT_GIB;
  assign running     = state == ST_RUN;
  assign status_data = last_code == CMD_MODE_GET ? {{(NB_ADDR_DATA-1){1'b0}}, mode}
                                                 : {{(NB_ADDR_DATA-NB_INSTR_ADDR){1'b0}}, load_cnt};
  assign status      = {last_code, 1'b1, 7'b0, mode, running, status_data};
  frame_edge_detect u_edge (
    .clock  (i_clock),
    .reset_n(i_reset),
    .code   (code),
    .valid  (i_frame_from_blaze[VALID_BIT]),
    .accept (accept)
  );
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state            <= ST_IDLE;
      ret_state        <= ST_IDLE;
      mode             <= 1'b1;
      last_code        <= '0;
      held_lsb         <= '0;
      load_cnt         <= '0;
      o_frame_to_blaze <= '0;
      o_pipe_enable    <= 1'b0;
      o_pipe_reset     <= 1'b0;
      o_req_type       <= '0;
      o_req_addr       <= '0;
      o_word_idx       <= '0;
      o_instr_we       <= 1'b0;
      o_instr_addr     <= '0;
      o_instr_data     <= '0;
    end else begin
      o_pipe_reset     <= 1'b0;
      o_instr_we       <= 1'b0;
      o_pipe_enable    <= running && !i_halt;
      o_frame_to_blaze <= state == ST_SEND ? i_data_word : status;
      if ((running || state == ST_ARMED) && i_halt) state <= ST_IDLE;
      // Later assignments in the decode below override the defaults above
      if (accept) begin
        last_code <= code;
        case (code)
          CMD_RESET: begin
            o_pipe_reset  <= 1'b1;
            o_pipe_enable <= 1'b0;
            load_cnt      <= '0;
            state         <= ST_IDLE;
            o_req_type    <= '0;
            o_req_addr    <= '0;
            o_word_idx    <= '0;
          end
          CMD_MODE_SET_CONT: if (!busy && !running) mode <= 1'b0;
          CMD_MODE_SET_STEP: if (!busy && !running) mode <= 1'b1;
          CMD_START: if (state == ST_IDLE) begin
            state         <= mode ? ST_ARMED : ST_RUN;
            o_pipe_enable <= !mode;
          end
          CMD_STEP: if (state == ST_ARMED) o_pipe_enable <= 1'b1;
          CMD_LOAD_LSB: if (!busy) held_lsb <= address;
          CMD_LOAD_MSB: if (!busy && !running) begin
            o_instr_we   <= 1'b1;
            o_instr_addr <= load_cnt;
            o_instr_data <= {address, held_lsb};
            load_cnt     <= load_cnt + 1'b1;
          end
          CMD_REQ_DATA: if (state == ST_IDLE || state == ST_ARMED) begin
            o_req_type <= addr_type;
            o_req_addr <= address;
            o_word_idx <= '0;
            ret_state  <= state;
            state      <= ST_SEND;
          end
          CMD_GOT_DATA: if (state == ST_SEND)
            state <= o_word_idx == last_word_idx(o_req_type) ? ret_state : ST_WAIT_GIB;
          CMD_GIB_DATA: if (state == ST_WAIT_GIB) begin
            o_word_idx <= o_word_idx + 1'b1;
            state      <= ST_SEND;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_debug_frame_controller.sv
// tb_debug_frame_controller: directed scenario tests for the debug frame controller
module tb_debug_frame_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] frame, data_word;
  logic        halt;
  logic [31:0] o_frame;
  logic        o_pipe_enable, o_pipe_reset, o_instr_we;
  logic [8:0]  o_req_type, o_instr_addr;
  logic [15:0] o_req_addr;
  logic [1:0]  o_word_idx;
  logic [31:0] o_instr_data;
  logic [31:0] words [0:3];
  int errors = 0, checks = 0;
  int en_cnt = 0, en_rise = 0, rst_cnt = 0, we_cnt = 0;
  logic prev_en = 1'b0;
  logic [8:0]  w_addr [0:7];
  logic [31:0] w_data [0:7];
  localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h4444_0002, WC = 32'h8888_0003;
  always #5 clk = ~clk;
  assign data_word = words[o_word_idx];
  debug_frame_controller dut (
    .i_clock(clk), .i_reset(rst_n), .i_frame_from_blaze(frame), .i_data_word(data_word), .i_halt(halt),
    .o_frame_to_blaze(o_frame), .o_pipe_enable(o_pipe_enable), .o_pipe_reset(o_pipe_reset),
    .o_req_type(o_req_type), .o_req_addr(o_req_addr), .o_word_idx(o_word_idx),
    .o_instr_we(o_instr_we), .o_instr_addr(o_instr_addr), .o_instr_data(o_instr_data)
  );
  always @(negedge clk) begin
    if (o_pipe_enable) en_cnt <= en_cnt + 1;
    if (o_pipe_enable && !prev_en) en_rise <= en_rise + 1;
    prev_en <= o_pipe_enable;
    if (o_pipe_reset) rst_cnt <= rst_cnt + 1;
    if (o_instr_we) begin
      w_addr[we_cnt[2:0]] <= o_instr_addr;
      w_data[we_cnt[2:0]] <= o_instr_data;
      we_cnt <= we_cnt + 1;
    end
  end
  task automatic send(input logic [5:0] c, input logic [8:0] t, input logic [15:0] a, input int n);
    frame = {c, 1'b1, t, a};
    repeat (n) @(negedge clk);
    frame = '0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    int b;
    rst_n = 1'b0;
    frame = '0;
    halt  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_frame, o_pipe_enable, o_pipe_reset, o_req_type, o_req_addr, o_word_idx, o_instr_we, o_instr_addr, o_instr_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: frame=%h en=%b prst=%b we=%b", o_frame, o_pipe_enable, o_pipe_reset, o_instr_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_frame !== 32'h0202_0000) begin errors++; $display("FAIL reset_status: got %h want 02020000", o_frame); end
    b = rst_cnt;
    send(6'b000010, 9'd0, 16'd0, 2);
    checks++;
    if (rst_cnt - b !== 1) begin errors++; $display("FAIL reset_pulse_count: got %0d want 1", rst_cnt - b); end
    send(6'b001000, 9'd0, 16'd0, 2);
    checks++;
    if (o_frame !== 32'h2202_0001) begin errors++; $display("FAIL mode_get: got %h want 22020001", o_frame); end
  endtask
  task automatic test_cont_run;
    int b;
    send(6'b001001, 9'd0, 16'd0, 2);
    b = en_cnt;
    frame = {6'b000001, 1'b1, 9'd0, 16'd0};
    @(negedge clk);
    @(negedge clk);
    frame = '0;
    repeat (3) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (en_cnt - b !== 5) begin errors++; $display("FAIL cont_enable_cycles: got %0d want 5", en_cnt - b); end
    checks++;
    if (o_frame !== 32'h0600_0000) begin errors++; $display("FAIL cont_idle_status: got %h want 06000000", o_frame); end
  endtask
  task automatic test_step;
    int b, r;
    send(6'b001010, 9'd0, 16'd0, 2);
    send(6'b000001, 9'd0, 16'd0, 2);
    b = en_cnt;
    r = en_rise;
    repeat (3) send(6'b100000, 9'd0, 16'd0, 2);
    checks++;
    if (en_cnt - b !== 3) begin errors++; $display("FAIL step_enable_cycles: got %0d want 3", en_cnt - b); end
    checks++;
    if (en_rise - r !== 3) begin errors++; $display("FAIL step_pulses: got %0d want 3", en_rise - r); end
  endtask
  task automatic test_load;
    int b;
    b = we_cnt;
    repeat (2) begin
      send(6'b000100, 9'd0, 16'h5678, 2);
      send(6'b000101, 9'd0, 16'h1234, 2);
    end
    checks++;
    if (we_cnt - b !== 2) begin errors++; $display("FAIL load_we_cycles: got %0d want 2", we_cnt - b); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (w_addr[b + i] !== 9'(i) || w_data[b + i] !== 32'h1234_5678) begin
        errors++; $display("FAIL load_write%0d: got addr=%0d data=%h want addr=%0d data=12345678", i, w_addr[b + i], w_data[b + i], i);
      end
    end
    checks++;
    if (o_frame !== 32'h1602_0002) begin errors++; $display("FAIL load_status: got %h want 16020002", o_frame); end
  endtask
  task automatic test_req_data;
    int b;
    logic [31:0] exp [0:2];
    exp[0] = WA; exp[1] = WB; exp[2] = WC;
    send(6'b000011, 9'd16, 16'h0042, 2);
    checks++;
    if (o_req_type !== 9'd16 || o_req_addr !== 16'h0042) begin
      errors++; $display("FAIL req_capture: got type=%h addr=%h want 010 0042", o_req_type, o_req_addr);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) send(6'b100101, 9'd0, 16'd0, 2);
      checks++;
      if (o_frame !== exp[i] || o_word_idx !== 2'(i)) begin
        errors++; $display("FAIL deco_word%0d: got frame=%h idx=%0d want %h idx=%0d", i, o_frame, o_word_idx, exp[i], i);
      end
      send(6'b100100, 9'd0, 16'd0, 2);
      checks++;
      if (o_frame !== 32'h9202_0002) begin errors++; $display("FAIL deco_got%0d_status: got %h want 92020002", i, o_frame); end
    end
    b = en_cnt;
    send(6'b100000, 9'd0, 16'd0, 2);
    checks++;
    if (en_cnt - b !== 1) begin errors++; $display("FAIL deco_return_armed: got %0d enable cycles want 1", en_cnt - b); end
    send(6'b000011, 9'd8, 16'h0007, 2);
    checks++;
    if (o_frame !== WA) begin errors++; $display("FAIL fetch_word0: got %h want %h", o_frame, WA); end
    send(6'b100100, 9'd0, 16'd0, 2);
    checks++;
    if (o_frame !== 32'h9202_0002) begin errors++; $display("FAIL fetch_got_status: got %h want 92020002", o_frame); end
    send(6'b100101, 9'd0, 16'd0, 2);
    checks++;
    if (o_frame !== 32'h9602_0002 || o_word_idx !== 2'd0) begin
      errors++; $display("FAIL fetch_gib_dropped: got frame=%h idx=%0d want 96020002 idx=0", o_frame, o_word_idx);
    end
    b = en_cnt;
    send(6'b100000, 9'd0, 16'd0, 2);
    checks++;
    if (en_cnt - b !== 1) begin errors++; $display("FAIL fetch_return_armed: got %0d enable cycles want 1", en_cnt - b); end
  endtask
  task automatic test_reset_abort;
    int b;
    send(6'b000011, 9'd16, 16'h0099, 2);
    send(6'b100100, 9'd0, 16'd0, 2);
    b = rst_cnt;
    send(6'b000010, 9'd0, 16'd0, 2);
    checks++;
    if (rst_cnt - b !== 1) begin errors++; $display("FAIL abort_pulse_count: got %0d want 1", rst_cnt - b); end
    checks++;
    if ({o_pipe_enable, o_req_type, o_req_addr, o_word_idx, o_instr_we} !== '0) begin
      errors++; $display("FAIL abort_outputs: en=%b type=%h addr=%h idx=%0d we=%b want all 0", o_pipe_enable, o_req_type, o_req_addr, o_word_idx, o_instr_we);
    end
    checks++;
    if (o_frame !== 32'h0A02_0000) begin errors++; $display("FAIL abort_status: got %h want 0a020000", o_frame); end
    b = en_cnt;
    send(6'b100000, 9'd0, 16'd0, 2);
    checks++;
    if (en_cnt - b !== 0) begin errors++; $display("FAIL abort_idle_step: got %0d enable cycles want 0", en_cnt - b); end
  endtask
  task automatic test_async_reset;
    send(6'b001001, 9'd0, 16'd0, 2);
    send(6'b000011, 9'd16, 16'h0055, 2);
    checks++;
    if (o_frame !== WA) begin errors++; $display("FAIL async_pre_send: got %h want %h", o_frame, WA); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_frame, o_pipe_enable, o_pipe_reset, o_req_type, o_req_addr, o_word_idx, o_instr_we, o_instr_addr, o_instr_data} !== '0) begin
      errors++; $display("FAIL async_outputs: frame=%h type=%h addr=%h idx=%0d addr=%0d", o_frame, o_req_type, o_req_addr, o_word_idx, o_instr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_frame !== 32'h0202_0000) begin errors++; $display("FAIL async_status: got %h want 02020000", o_frame); end
  endtask
  initial begin
    words[0] = WA; words[1] = WB; words[2] = WC; words[3] = 32'hDEAD_0000;
    rst_n = 1'b0;
    frame = '0;
    halt  = 1'b0;
    @(negedge clk);
    test_reset;
    test_cont_run;
    test_step;
    test_load;
    test_req_data;
    test_reset_abort;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
